// File: rtl/itf_prio.sv
// Multi-channel interrupt front-end: edge capture, enable mask, fixed-priority
// selection and in-service tracking. Nested preemption is enabled by ITF_PRIO_NEST_EN.
module itf_prio #(
    parameter int NCH        = 8,
    parameter int VW         = 5,
    parameter int NEST_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] irq,
    input  logic           mask_wr,
    input  logic [NCH-1:0] mask_in,
    input  logic           svc,
    input  logic           rit,
    input  logic           ex0,
    input  logic           ex1,
    input  logic           it0,
    input  logic           it2,
    output logic           ita,
    output logic           itf,
    output logic [VW-1:0]  vec,
    output logic           eit,
    output logic           oit,
    output logic [NCH:0]   pend_q,
    output logic [NCH-1:0] mask_q
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [VW-1:0] SVC_VEC = VW'(NCH);

    state_t         state_q, state_d;
    logic [NCH-1:0] irq_d;
    logic [NCH:0]   elig, pend_d;
    logic [VW-1:0]  sel;
    logic           any_elig, want, preempt, accept, retire;

    assign elig     = pend_q & {1'b1, mask_q};
    assign any_elig = |elig;

    // SVC beats every channel; among channels the lowest index wins.
    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig[i]) sel = VW'(i);
        end
        if (elig[NCH]) sel = SVC_VEC;
    end

`ifdef ITF_PRIO_NEST_EN
    localparam int SPW = $clog2(NEST_DEPTH + 1);

    logic [SPW-1:0]  sp_q;
    logic [VW+1:0]   stack [NEST_DEPTH];
    logic [VW+1:0]   top;

    // Rank 0 is the most urgent; SVC maps to 0, channel i to i+1.
    function automatic logic [VW-1:0] rank(input logic [VW-1:0] v);
        return (v == SVC_VEC) ? '0 : v + VW'(1);
    endfunction

    assign preempt = (sp_q < SPW'(NEST_DEPTH)) && any_elig && (rank(sel) < rank(vec));

    always_comb begin
        top = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) top = stack[i];
        end
    end

    // NOTE: the stack array has no reset; sp_q is reset, so stale entries are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (accept && itf && sp_q == SPW'(i)) stack[i] <= {vec, eit, oit};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sp_q <= '0;
        end else if (accept && itf) begin
            sp_q <= sp_q + SPW'(1);
        end else if (retire && sp_q != '0) begin
            sp_q <= sp_q - SPW'(1);
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // While already in service only a preempting source may hold the request.
    assign want = itf ? preempt : any_elig;
    assign ita  = (state_q == REQ) && want;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_elig && !itf) state_d = REQ;
            end
            REQ: begin
                if (!want) begin
                    state_d = itf ? SERVICE : IDLE;
                end else if (it0) begin
                    accept  = 1'b1;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (rit && ex0) begin
                    retire  = 1'b1;
`ifdef ITF_PRIO_NEST_EN
                    state_d = (sp_q == '0) ? IDLE : SERVICE;
`else
                    state_d = IDLE;
`endif
                end else if (preempt) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Acceptance clears the served bit first so a same-cycle edge re-sets it.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i <= NCH; i++) begin
            if (accept && sel == VW'(i)) pend_d[i] = 1'b0;
        end
        pend_d[NCH-1:0] = pend_d[NCH-1:0] | (irq & ~irq_d);
        pend_d[NCH]     = pend_d[NCH] | (svc & ex1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments for all registered state.
            state_q <= IDLE;
            irq_d   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            itf     <= 1'b0;
            vec     <= '0;
            eit     <= 1'b0;
            oit     <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_d   <= irq;
            pend_q  <= pend_d;
            if (mask_wr) mask_q <= mask_in;
            if (accept) begin
                itf <= 1'b1;
                vec <= sel;
                eit <= (sel < SVC_VEC);
                oit <= (sel == SVC_VEC);
            end else if (retire) begin
`ifdef ITF_PRIO_NEST_EN
                if (sp_q == '0) begin
                    itf <= 1'b0;
                    eit <= 1'b0;
                    oit <= 1'b0;
                end else begin
                    {vec, eit, oit} <= top;
                end
`else
                itf <= 1'b0;
                eit <= 1'b0;
                oit <= 1'b0;
`endif
            end
        end
    end

    // it2 marks the end of interrupt entry and carries no state here.
    logic unused_ok;
    assign unused_ok = ^{1'b0, it2};

endmodule

// File: tb/tb_itf_prio.sv
// Scoreboard bench for itf_prio: acceptances are queued by the stimulus and
// checked by an independent monitor; register state is checked directly.
module tb_itf_prio;

    localparam int NCH = 8;
    localparam int VW  = 5;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] irq;
    logic           mask_wr;
    logic [NCH-1:0] mask_in;
    logic           svc, rit, ex0, ex1, it0, it2;
    logic           ita, itf, eit, oit;
    logic [VW-1:0]  vec;
    logic [NCH:0]   pend_q;
    logic [NCH-1:0] mask_q;

    typedef struct {
        logic [VW-1:0] vec;
        logic          eit;
        logic          oit;
    } acc_t;

    acc_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    itf_prio #(.NCH(NCH), .VW(VW), .NEST_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .irq     (irq),
        .mask_wr (mask_wr),
        .mask_in (mask_in),
        .svc     (svc),
        .rit     (rit),
        .ex0     (ex0),
        .ex1     (ex1),
        .it0     (it0),
        .it2     (it2),
        .ita     (ita),
        .itf     (itf),
        .vec     (vec),
        .eit     (eit),
        .oit     (oit),
        .pend_q  (pend_q),
        .mask_q  (mask_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [VW-1:0] v, input logic e, input logic o);
        acc_t a;
        a.vec = v;
        a.eit = e;
        a.oit = o;
        exp_q.push_back(a);
    endtask

    task automatic wait_ita(input string name);
        int n = 0;
        while (!ita && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'd0, ita}, 32'd1);
    endtask

    task automatic write_mask(input logic [NCH-1:0] m);
        mask_wr = 1'b1;
        mask_in = m;
        tick();
        mask_wr = 1'b0;
    endtask

    task automatic do_rit();
        rit = 1'b1;
        ex0 = 1'b1;
        tick();
        rit = 1'b0;
        ex0 = 1'b0;
    endtask

    // Full entry/exit of one source; the accepted vector is checked by the monitor.
    task automatic serve(input string name, input logic [VW-1:0] v, input logic e, input logic o);
        wait_ita({name, "_ita"});
        push(v, e, o);
        it0 = 1'b1;
        tick();
        it0 = 1'b0;
        check({name, "_itf_set"}, {31'd0, itf}, 32'd1);
        do_rit();
        check({name, "_itf_clr"}, {31'd0, itf}, 32'd0);
    endtask

    // Monitor: an acceptance is ita & it0 at a rising edge; results appear just after.
    initial begin
        acc_t a;
        forever begin
            @(posedge clk);
            if (reset_n && ita && it0) begin
                #1;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_accept", {27'd0, vec}, 32'hFFFF_FFFF);
                end else begin
                    a = exp_q.pop_front();
                    check("sb_vec", {27'd0, vec}, {27'd0, a.vec});
                    check("sb_eit", {31'd0, eit}, {31'd0, a.eit});
                    check("sb_oit", {31'd0, oit}, {31'd0, a.oit});
                    check("sb_itf", {31'd0, itf}, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        irq     = '0;
        mask_wr = 1'b0;
        mask_in = '0;
        {svc, rit, ex0, ex1, it0, it2} = '0;
        tick();
        tick();
        check("rst_ita",  {31'd0, ita}, 32'd0);
        check("rst_itf",  {31'd0, itf}, 32'd0);
        check("rst_pend", {23'd0, pend_q}, 32'd0);
        check("rst_mask", {24'd0, mask_q}, 32'd0);
        check("rst_vec",  {27'd0, vec}, 32'd0);
        reset_n = 1'b1;

        // Single edge on channel 3: pending next cycle, request the cycle after.
        write_mask(8'hFF);
        check("mask_ff", {24'd0, mask_q}, 32'hFF);
        irq = 8'h08;
        tick();
        check("t1_pend", {23'd0, pend_q}, 32'h008);
        check("t1_ita_early", {31'd0, ita}, 32'd0);
        tick();
        check("t1_ita", {31'd0, ita}, 32'd1);
        push(5'd3, 1'b1, 1'b0);
        it0 = 1'b1;
        it2 = 1'b1;
        tick();
        it0 = 1'b0;
        it2 = 1'b0;
        check("t1_pend_clr", {23'd0, pend_q}, 32'h000);
        check("t1_itf", {31'd0, itf}, 32'd1);
        check("t1_ita_off", {31'd0, ita}, 32'd0);
        do_rit();
        check("t1_itf_clr", {31'd0, itf}, 32'd0);
        check("t1_eit_clr", {31'd0, eit}, 32'd0);
        check("t1_vec_hold", {27'd0, vec}, 32'd3);
        irq = '0;
        tick();

        // SVC plus channels 5 and 1 together: SVC, then 1, then 5.
        irq = 8'h22;
        svc = 1'b1;
        ex1 = 1'b1;
        tick();
        svc = 1'b0;
        ex1 = 1'b0;
        check("t2_pend", {23'd0, pend_q}, 32'h122);
        serve("t2_svc", 5'd8, 1'b0, 1'b1);
        serve("t2_ch1", 5'd1, 1'b1, 1'b0);
        serve("t2_ch5", 5'd5, 1'b1, 1'b0);
        irq = '0;
        tick();

        // Masked channel 2 pends without request until enabled.
        write_mask(8'hFB);
        irq = 8'h04;
        tick();
        check("t3_pend", {23'd0, pend_q}, 32'h004);
        check("t3_ita_masked", {31'd0, ita}, 32'd0);
        tick();
        check("t3_ita_masked2", {31'd0, ita}, 32'd0);
        write_mask(8'hFF);
        check("t3_ita_wr", {31'd0, ita}, 32'd0);
        tick();
        check("t3_ita_en", {31'd0, ita}, 32'd1);
        serve("t3_ch2", 5'd2, 1'b1, 1'b0);
        irq = '0;
        tick();

        // Request for channel 4 withdrawn when its mask bit is cleared.
        irq = 8'h10;
        tick();
        check("t4_pend", {23'd0, pend_q}, 32'h010);
        tick();
        check("t4_ita", {31'd0, ita}, 32'd1);
        write_mask(8'hEF);
        check("t4_ita_drop", {31'd0, ita}, 32'd0);
        tick();
        check("t4_ita_idle", {31'd0, ita}, 32'd0);
        check("t4_pend_keep", {23'd0, pend_q}, 32'h010);
        write_mask(8'hFF);
        check("t4_ita_rewr", {31'd0, ita}, 32'd0);
        tick();
        check("t4_ita_back", {31'd0, ita}, 32'd1);
        serve("t4_ch4", 5'd4, 1'b1, 1'b0);
        irq = '0;
        tick();

        // Reset in the middle of service clears everything.
        irq = 8'h0B;
        tick();
        wait_ita("t5_ita");
        push(5'd0, 1'b1, 1'b0);
        it0 = 1'b1;
        tick();
        it0 = 1'b0;
        check("t5_pend_svc", {23'd0, pend_q}, 32'h00A);
        reset_n = 1'b0;
        irq     = '0;
        tick();
        reset_n = 1'b1;
        check("t5_itf",  {31'd0, itf}, 32'd0);
        check("t5_ita",  {31'd0, ita}, 32'd0);
        check("t5_pend", {23'd0, pend_q}, 32'd0);
        check("t5_mask", {24'd0, mask_q}, 32'd0);
        check("t5_vec",  {27'd0, vec}, 32'd0);
        check("t5_eit",  {31'd0, eit}, 32'd0);

        // Stray it0 and rit in IDLE have no effect.
        it0 = 1'b1;
        tick();
        it0 = 1'b0;
        do_rit();
        check("spur_itf", {31'd0, itf}, 32'd0);
        check("spur_ita", {31'd0, ita}, 32'd0);

        // New edge on the bit being accepted: set wins.
        write_mask(8'hFF);
        irq = 8'h40;
        tick();
        check("t6_pend", {23'd0, pend_q}, 32'h040);
        irq = 8'h00;
        tick();
        check("t6_ita", {31'd0, ita}, 32'd1);
        push(5'd6, 1'b1, 1'b0);
        irq = 8'h40;
        it0 = 1'b1;
        tick();
        it0 = 1'b0;
        check("t6_pend_set_wins", {23'd0, pend_q}, 32'h040);
        check("t6_itf", {31'd0, itf}, 32'd1);
        do_rit();
        serve("t6_again", 5'd6, 1'b1, 1'b0);
        irq = '0;
        tick();

        // Channel 0 arriving while channel 6 is in service.
        irq = 8'h40;
        tick();
        wait_ita("t7_ita6");
        push(5'd6, 1'b1, 1'b0);
        it0 = 1'b1;
        tick();
        it0 = 1'b0;
        irq = 8'h41;
        tick();
        tick();
`ifdef ITF_PRIO_NEST_EN
        check("t7_preempt_ita", {31'd0, ita}, 32'd1);
        push(5'd0, 1'b1, 1'b0);
        it0 = 1'b1;
        tick();
        it0 = 1'b0;
        check("t7_nest_itf", {31'd0, itf}, 32'd1);
        do_rit();
        check("t7_pop_vec", {27'd0, vec}, 32'd6);
        check("t7_pop_itf", {31'd0, itf}, 32'd1);
        check("t7_pop_eit", {31'd0, eit}, 32'd1);
        do_rit();
        check("t7_last_itf", {31'd0, itf}, 32'd0);
`else
        check("t7_no_preempt", {31'd0, ita}, 32'd0);
        check("t7_pend0", {23'd0, pend_q}, 32'h001);
        do_rit();
        check("t7_itf_clr", {31'd0, itf}, 32'd0);
        serve("t7_ch0", 5'd0, 1'b1, 1'b0);
`endif
        irq = '0;
        tick();
        tick();

        check("sb_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/itf_prio.md
Name: itf_prio

Overview:
- Parametrised multi-channel interrupt front-end. It is the successor to the single-source interrupt flag unit.
- Latches NCH external interrupt edges plus the SVC software trap, and applies a per-channel enable mask.
- Picks the highest-priority source and drives ITA to the state sequencer. Provides a vector and the EIT/OIT class flags to the ISR decoder.
- Tracks in-service state via ITF until RIT.

Parameters:
- NCH, 8, number of external interrupt channels (1..16); channel 0 has the highest priority.
- VW, 5, vector width; must satisfy 2^VW > NCH. Vector NCH is the SVC vector.
- NEST_DEPTH, 4, in-service stack depth; used only with ITF_PRIO_NEST_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- irq  in  NCH  external interrupt lines, level; a rising edge is detected internally
- mask_wr  in  1  write strobe for the enable mask
- mask_in  in  NCH  new enable mask; 1 = enabled
- svc  in  1  op_SVC from the decoder, qualified by ex1
- rit  in  1  op_RIT from the decoder, qualified by ex0
- ex0  in  1  sequencer state EX0
- ex1  in  1  sequencer state EX1
- it0  in  1  sequencer state IT0; acceptance point
- it2  in  1  sequencer state IT2; end of interrupt entry
- ita  out  1  interrupt accept request to the sequencer
- itf  out  1  in-service flag; 1 = an interrupt is being serviced
- vec  out  VW  vector of the accepted source
- eit  out  1  accepted source is external
- oit  out  1  accepted source is SVC
- pend_q  out  NCH+1  pending register, bit NCH = SVC (debug)
- mask_q  out  NCH  current enable mask

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (reset_n=0 at a clk edge) clears: pend_q, mask_q (all channels disabled), irq edge history, itf, ita, vec, eit, oit. FSM goes to IDLE. The same applies mid-service: no state survives.
- Edge detect:
  - irq_d is the irq value registered on the previous cycle.
  - pend_q[i] is set when irq[i] & ~irq_d[i]. Pending is set regardless of the mask.
  - pend_q[NCH] is set when svc & ex1.
- Mask: on mask_wr, mask_q <= mask_in with effect from the next cycle.
- Eligibility: elig = pend_q & {1'b1, mask_q}. SVC cannot be masked.
- Priority: SVC is highest, then channel 0 down to channel NCH-1. sel is the winning index.
- FSM (registered):
  - IDLE: ita=0. If elig is non-zero and itf=0, go to REQ.
  - REQ: ita=1.
    - If it0=1, accept: vec <= sel, with sel evaluated in this cycle, not at REQ entry. Clear pend_q[sel]. itf <= 1. eit <= (sel<NCH). oit <= (sel==NCH). Go to SERVICE.
    - If elig becomes zero before it0 (source masked off), withdraw: ita drops and the FSM returns to IDLE.
  - SERVICE: ita=0. vec, eit and oit hold. If rit & ex0: itf <= 0, eit/oit <= 0, go to IDLE. vec holds until the next acceptance.
- Latency:
  - Edge on irq (cycle n): pend_q set at n+1, ita=1 at n+2.
  - it0 in cycle k: itf=1 and vec valid from k+1.
- Spurious events:
  - it0 in IDLE or SERVICE: ignored.
  - rit outside SERVICE: ignored.
  - it2 has no state effect in the base configuration.
- Simultaneous events:
  - A new edge and an acceptance clear on the same bit in the same cycle: set wins, and the bit stays pending.
  - svc and external edges together: all are latched; SVC is served first.
  - mask_wr in the same cycle as it0: the old mask decides sel.
- Width rules: vec is zero-extended to VW. pend_q and mask_q are not wrapped.

Optional Feature:
- Macro ITF_PRIO_NEST_EN.
- Defined:
  - In SERVICE, a pending eligible source with priority strictly higher than the current top of stack raises ita again. The FSM returns to REQ while itf stays 1.
  - On it0 the current {vec,eit,oit} is pushed onto a NEST_DEPTH-entry stack.
  - On rit & ex0 the stack is popped, restoring the previous vec/eit/oit. itf clears only when the stack becomes empty.
  - Stack full: further preemption is blocked and ita stays 0 until a pop.
- Undefined: no preemption. A pending source waits for RIT, and there is no stack logic.

Test Plan:
- Reset, then set mask_in=8'hFF with mask_wr, then pulse irq[3] 0→1: pend_q[3]=1 next cycle, ita=1 the cycle after; it0 → vec=3, eit=1, oit=0, itf=1, pend_q[3]=0.
- Edges on irq[5] and irq[1] in the same cycle plus svc&ex1: first accept vec=8 with oit=1; after rit&ex0, vec=1; then vec=5.
- irq[2] edge with mask_q[2]=0: pend_q[2]=1, ita=0. Write mask_q[2]=1: ita=1 two cycles after the edge condition is met, vec=2 on it0.
- In REQ for irq[4], clear mask_q[4] before it0: ita drops and the FSM returns to IDLE; pend_q[4] remains 1.
- Drive reset_n=0 for one cycle during SERVICE with pend_q=9'h0A: next cycle itf=0, ita=0, pend_q=0, mask_q=0, vec=0.
- With ITF_PRIO_NEST_EN: serve irq[6], then an irq[0] edge during SERVICE → ita=1, vec=0. First rit → vec=6 with itf=1; second rit → itf=0.
